// File: rtl/arbitro_mostrador.sv
// -----------------------------------------------------------------------------
// arbitro_mostrador
//
// Shares the single 7-segment display between three sources (fontes 0..2).
// One owner at a time, picked round-robin. An owner keeps the display for at
// least TEMPO_MIN+1 cycles (no flicker). It is preempted once its counter
// reaches TEMPO_MAX and another source is waiting (no starvation). A
// one-cycle blanking slot separates consecutive owners.
//
// Parameters:
//   TEMPO_MIN  minimum counter value before a grant may be released (1..TEMPO_MAX)
//   TEMPO_MAX  counter value at which a waiting source preempts the owner
//   LARG_CONT  counter width, 2**LARG_CONT > TEMPO_MAX
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   req[2:0]       in   level request, bit i = fonte i
//   urgente        in   alarm request for fonte2 (only with MOSTRADOR_URGENTE_EN)
//   grant[2:0]     out  one-hot registered grant, 000 = no owner
//   sel_mostrador  out  00 blank, 01 fonte0, 10 fonte1, 11 fonte2
//   apagar         out  high during the blanking slot between owners
//   ocupado        out  high whenever grant != 000
//
// Optional feature macro: MOSTRADOR_URGENTE_EN
//   Adds the urgente port. urgente forces fonte2 onto the display: it cuts the
//   current owner short (ignoring TEMPO_MIN), wins the next grant regardless
//   of round-robin, and suspends TEMPO_MAX preemption while it stays high.
// -----------------------------------------------------------------------------
module arbitro_mostrador #(
  parameter int TEMPO_MIN = 4,
  parameter int TEMPO_MAX = 200,
  parameter int LARG_CONT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
`ifdef MOSTRADOR_URGENTE_EN
  input  logic       urgente,
`endif
  output logic [2:0] grant,
  output logic [1:0] sel_mostrador,
  output logic       apagar,
  output logic       ocupado
);

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    CONCEDIDO = 2'd1,
    APAGA     = 2'd2
  } estado_t;

  localparam logic [LARG_CONT-1:0] MIN_C = LARG_CONT'(TEMPO_MIN);
  localparam logic [LARG_CONT-1:0] MAX_C = LARG_CONT'(TEMPO_MAX);

  estado_t              r_estado;
  logic [LARG_CONT-1:0] r_cont;
  logic [1:0]           r_ultimo;   // last winner; equals the owner while CONCEDIDO

  estado_t              w_estado_prox;
  logic [LARG_CONT-1:0] w_cont_prox;
  logic [1:0]           w_ultimo_prox;
  logic [1:0]           w_vencedor;
  logic [2:0]           w_dono_oh;
  logic                 w_dono_req;
  logic                 w_outros;
  logic                 w_urg;
  logic                 w_lib_a;
  logic                 w_lib_b;
  logic                 w_lib_u;

  // Index after i, modulo 3.
  function automatic logic [1:0] prox_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Round-robin: search ultimo+1, ultimo+2, ultimo+3 (mod 3). Candidates are
  // applied in reverse priority so the highest-priority hit overwrites last.
  function automatic logic [1:0] escolhe_rr(input logic [2:0] r, input logic [1:0] ult);
    logic [1:0] i1;
    logic [1:0] i2;
    logic [1:0] res;
    i1  = prox_idx(ult);
    i2  = prox_idx(i1);
    res = ult;
    if (r[i2]) res = i2;
    if (r[i1]) res = i1;
    return res;
  endfunction

`ifdef MOSTRADOR_URGENTE_EN
  assign w_urg = urgente;
`else
  assign w_urg = 1'b0;
`endif

  assign w_vencedor = escolhe_rr(req, r_ultimo);
  assign w_dono_oh  = 3'b001 << r_ultimo;
  assign w_dono_req = |(req & w_dono_oh);
  assign w_outros   = |(req & ~w_dono_oh);

  // Release A: owner let go and the minimum hold has been served.
  assign w_lib_a = !w_dono_req && (r_cont >= MIN_C);
  // Release B: maximum hold reached with someone waiting; an urgent fonte2
  // owner is immune while urgente is held.
  assign w_lib_b = (r_cont >= MAX_C) && w_outros && !(w_urg && (r_ultimo == 2'd2));
  // Urgent cut: any non-fonte2 owner leaves immediately.
  assign w_lib_u = w_urg && (r_ultimo != 2'd2);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    w_estado_prox = r_estado;
    w_cont_prox   = r_cont;
    w_ultimo_prox = r_ultimo;
    case (r_estado)
      OCIOSO, APAGA: begin
        w_cont_prox = '0;
        if (w_urg) begin
          w_estado_prox = CONCEDIDO;
          w_ultimo_prox = 2'd2;
        end else if (|req) begin
          w_estado_prox = CONCEDIDO;
          w_ultimo_prox = w_vencedor;
        end else begin
          w_estado_prox = OCIOSO;
        end
      end
      CONCEDIDO: begin
        if (w_lib_a || w_lib_b || w_lib_u) begin
          w_estado_prox = APAGA;
        end else if (r_cont < MAX_C) begin
          w_cont_prox = r_cont + 1'b1;
        end
      end
      default: begin
        w_estado_prox = OCIOSO;
        w_cont_prox   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state values, so they are coherent
  // with the state register and have no combinational path from req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado      <= OCIOSO;
      r_cont        <= '0;
      r_ultimo      <= 2'd2;   // fonte0 wins first after reset
      grant         <= 3'b000;
      sel_mostrador <= 2'b00;
      apagar        <= 1'b0;
      ocupado       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the values from before this edge.
      r_estado <= w_estado_prox;
      r_cont   <= w_cont_prox;
      r_ultimo <= w_ultimo_prox;
      if (w_estado_prox == CONCEDIDO) begin
        grant         <= 3'b001 << w_ultimo_prox;
        sel_mostrador <= w_ultimo_prox + 2'd1;
        ocupado       <= 1'b1;
      end else begin
        grant         <= 3'b000;
        sel_mostrador <= 2'b00;
        ocupado       <= 1'b0;
      end
      apagar <= (w_estado_prox == APAGA);
    end
  end

endmodule
